// File: rtl/pwm_capture.sv
// pwm_capture: Avalon-MM slave that measures the high time and period of an
// external PWM signal in clock cycles. Registers: 0 HIGH, 1 PERIOD_HOLD,
// 2 STATUS {overrun, timeout, level, valid}, 3 CONTROL {clear, enable}.
module pwm_capture #(
  parameter int unsigned CNT_W           = 32,
  parameter int unsigned TIMEOUT_CYCLES  = 5000000,
  parameter bit          ENABLE_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pwm_in,
  input  logic [1:0]  avs_address,
  input  logic        avs_chipselect,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HIGH  = 2'd1;
  localparam logic [1:0] S_LOW   = 2'd2;
  localparam logic [1:0] S_STALL = 2'd3;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             pwm_meta, pwm_sync, pwm_prev;
  logic             rise, fall;
  logic [1:0]       state, state_nxt;
  logic             publish, enter_stall, capture_high;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_tmp;
  logic [CNT_W-1:0] high_r, period_r, period_hold;
  logic             valid, timeout, overrun, enable;
  logic             rd_strobe, rd_high, wr_ctrl, clear;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign rise      = pwm_sync & ~pwm_prev;
  assign fall      = ~pwm_sync & pwm_prev;
  assign rd_strobe = avs_chipselect & avs_read;
  assign rd_high   = rd_strobe & (avs_address == 2'd0);
  assign wr_ctrl   = avs_chipselect & avs_write & (avs_address == 2'd3);
  assign clear     = wr_ctrl & avs_writedata[1];
  assign unused_wdata = ^avs_writedata[31:2];

  // Two-flop synchroniser followed by an edge-detect flop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_meta <= 1'b0;
      pwm_sync <= 1'b0;
      pwm_prev <= 1'b0;
    end else begin
      pwm_meta <= pwm_in;
      pwm_sync <= pwm_meta;
      pwm_prev <= pwm_sync;
    end
  end

  // Measurement FSM next-state and publish/stall decisions
  always_comb begin
    state_nxt    = state;
    publish      = 1'b0;
    enter_stall  = 1'b0;
    capture_high = 1'b0;
    case (state)
      S_IDLE:  if (rise) state_nxt = S_HIGH;
      S_HIGH: begin
        if (fall) begin
          capture_high = 1'b1;
          state_nxt    = S_LOW;
        end else if (cnt == TIMEOUT_VAL) begin
          enter_stall = 1'b1;
          state_nxt   = S_STALL;
        end
      end
      S_LOW: begin
        if (rise) begin
          publish   = 1'b1;
          state_nxt = S_HIGH;
        end else if (cnt == TIMEOUT_VAL) begin
          enter_stall = 1'b1;
          state_nxt   = S_STALL;
        end
      end
      S_STALL: if (rise) state_nxt = S_HIGH;
      default: state_nxt = S_IDLE;
    endcase
    if (!enable) begin
      state_nxt    = S_IDLE;
      publish      = 1'b0;
      enter_stall  = 1'b0;
      capture_high = 1'b0;
    end
  end

  // FSM state, saturating cycle counter and captured high time
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      high_tmp <= '0;
    end else begin
      state <= state_nxt;
      if (!enable)
        cnt <= '0;
      else if (rise)
        cnt <= CNT_ONE;
      else if (cnt != '1)
        cnt <= cnt + CNT_ONE;
      if (capture_high)
        high_tmp <= cnt;
    end
  end

  // Published results, status flags and control register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      high_r      <= '0;
      period_r    <= '0;
      period_hold <= '0;
      valid       <= 1'b0;
      timeout     <= 1'b0;
      overrun     <= 1'b0;
      enable      <= ENABLE_ON_RESET;
    end else begin
      if (wr_ctrl)
        enable <= avs_writedata[0];
      // HOLD takes the pre-publish PERIOD so it pairs with the HIGH being read
      if (rd_high)
        period_hold <= period_r;
      if (publish) begin
        high_r   <= high_tmp;
        period_r <= cnt;
        valid    <= 1'b1;
      end else if (enter_stall) begin
        high_r   <= '0;
        period_r <= '0;
        valid    <= 1'b1;
      end else if (rd_high) begin
        valid <= 1'b0;
      end
      if (publish && valid && !rd_high)
        overrun <= 1'b1;
      else if (clear)
        overrun <= 1'b0;
      if (enter_stall)
        timeout <= 1'b1;
      else if (clear)
        timeout <= 1'b0;
    end
  end

  // Register read multiplexer
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      2'd0: rd_mux = 32'(high_r);
      2'd1: rd_mux = 32'(period_hold);
      2'd2: rd_mux = {28'd0, overrun, timeout, pwm_sync, valid};
      2'd3: rd_mux = {31'd0, enable};
      default: rd_mux = '0;
    endcase
  end

  // Registered read data, held between reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      avs_readdata <= '0;
    else if (rd_strobe)
      avs_readdata <= rd_mux;
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: drives a PWM pattern and Avalon reads/writes, predicts every
// read result with a timestamp-based model and checks them in a monitor.
module tb_pwm_capture;

  localparam int unsigned TO   = 1000;
  localparam logic [31:0] FULL = 32'hFFFF_FFFF;
  localparam int PH_WAIT = 0, PH_HIGH = 1, PH_LOW = 2, PH_STALL = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pwm_in = 1'b0;
  logic [1:0]  avs_address = '0;
  logic        avs_chipselect = 1'b0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;

  always #5 clk = ~clk;

  pwm_capture #(
    .CNT_W(32),
    .TIMEOUT_CYCLES(TO),
    .ENABLE_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .pwm_in(pwm_in),
    .avs_address(avs_address),
    .avs_chipselect(avs_chipselect),
    .avs_read(avs_read),
    .avs_write(avs_write),
    .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata)
  );

  // PWM generator: mode 0 toggles hi_len/lo_len, 1 holds high, 2 holds low
  int hi_len = 30, lo_len = 70, mode = 2;
  int per_idx = -1, gen_pos = 0, restart_req = 0;

  initial begin
    int pos = 0, cur_hi = 1, cur_lo = 1, ack = 0;
    forever begin
      @(negedge clk);
      if (ack != restart_req) begin
        ack = restart_req;
        pos = 0;
      end
      if (mode == 0) begin
        if (pos == 0) begin
          cur_hi = hi_len;
          cur_lo = lo_len;
          per_idx++;
        end
        gen_pos = pos;
        pwm_in  = (pos < cur_hi);
        pos++;
        if (pos >= cur_hi + cur_lo) pos = 0;
      end else begin
        pwm_in = (mode == 1);
      end
    end
  end

  // Scoreboard queues
  typedef struct {
    logic [1:0]  addr;
    logic [31:0] mask;
    logic [31:0] val;
  } dir_t;
  int unsigned model_q[$];
  dir_t        dir_q[$];

  // Reference model: edges are time-stamped (2-cycle synchroniser lag),
  // lengths are differences of timestamps.
  initial begin
    int unsigned t = 0, t_rise = 0, t_high = 0, el = 0, val = 0;
    int unsigned m_high = 0, m_period = 0, m_hold = 0;
    int          m_phase = PH_WAIT;
    bit          m_valid = 0, m_timeout = 0, m_overrun = 0, m_en = 1;
    bit [2:0]    hist = '0;
    bit          rise, fall, rd, rd0, wr3, pub, stall;
    int unsigned new_high, new_period;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        t = 0; t_rise = 0; t_high = 0;
        m_high = 0; m_period = 0; m_hold = 0; m_phase = PH_WAIT;
        m_valid = 0; m_timeout = 0; m_overrun = 0; m_en = 1; hist = '0;
      end else begin
        rise = hist[1] & ~hist[2];
        fall = ~hist[1] & hist[2];
        rd   = avs_chipselect & avs_read;
        rd0  = rd && (avs_address == 2'd0);
        wr3  = avs_chipselect && avs_write && (avs_address == 2'd3);
        if (rd) begin
          case (avs_address)
            2'd0: val = m_high;
            2'd1: val = m_hold;
            2'd2: val = {28'd0, m_overrun, m_timeout, hist[1], m_valid};
            default: val = {31'd0, m_en};
          endcase
          model_q.push_back(val);
        end
        pub = 0; stall = 0; new_high = 0; new_period = 0;
        el = t - t_rise;
        if (m_en) begin
          case (m_phase)
            PH_WAIT, PH_STALL: if (rise) begin m_phase = PH_HIGH; t_rise = t; end
            PH_HIGH: begin
              if (fall) begin t_high = el; m_phase = PH_LOW; end
              else if (el == TO) begin stall = 1; m_phase = PH_STALL; end
            end
            default: begin
              if (rise) begin
                pub = 1; new_high = t_high; new_period = el;
                t_rise = t; m_phase = PH_HIGH;
              end else if (el == TO) begin
                stall = 1; m_phase = PH_STALL;
              end
            end
          endcase
        end else begin
          m_phase = PH_WAIT;
        end
        if (rd0) m_hold = m_period;
        if (wr3 && avs_writedata[1]) begin m_timeout = 0; m_overrun = 0; end
        if (wr3) m_en = avs_writedata[0];
        if (pub) begin
          if (m_valid && !rd0) m_overrun = 1;
          m_high = new_high; m_period = new_period; m_valid = 1;
        end else if (stall) begin
          m_high = 0; m_period = 0; m_valid = 1; m_timeout = 1;
        end else if (rd0) begin
          m_valid = 0;
        end
        hist = {hist[1:0], pwm_in};
        t++;
      end
    end
  end

  // Monitor: every read presents its data the following cycle
  int n_checks = 0, n_fail = 0;
  int rst_req = 0, wt_req = 0;
  logic [31:0] rst_snap = '0;

  initial begin
    int rst_seen = 0, wt_seen = 0;
    int unsigned exp_v;
    dir_t d;
    forever begin
      @(negedge clk);
      if (rst_seen != rst_req) begin
        rst_seen = rst_req;
        n_checks++;
        if (rst_snap != 32'd0) begin
          n_fail++;
          $display("FAIL reset_readdata: got 0x%08h expected 0x00000000", rst_snap);
        end
      end
      if (wt_seen != wt_req) begin
        wt_seen = wt_req;
        n_checks++;
        n_fail++;
        $display("FAIL wait_bound: got expired wait expected generator position reached");
      end
      while (model_q.size() > 0) begin
        exp_v = model_q.pop_front();
        n_checks++;
        if (dir_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_order: got read data 0x%08h expected a pending read", avs_readdata);
        end else begin
          d = dir_q.pop_front();
          if (avs_readdata != exp_v) begin
            n_fail++;
            $display("FAIL rd_addr%0d_model: got 0x%08h expected 0x%08h", d.addr, avs_readdata, exp_v);
          end
          if (d.mask != 32'd0) begin
            n_checks++;
            if ((avs_readdata & d.mask) != d.val) begin
              n_fail++;
              $display("FAIL rd_addr%0d_directed: got 0x%08h expected 0x%08h under mask 0x%08h",
                       d.addr, avs_readdata & d.mask, d.val, d.mask);
            end
          end
        end
      end
    end
  end

  task automatic rd(input logic [1:0] a, input logic [31:0] mask, input logic [31:0] val);
    dir_t d;
    @(negedge clk);
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = a;
    d.addr = a; d.mask = mask; d.val = val;
    dir_q.push_back(d);
    @(negedge clk);
    avs_chipselect = 1'b0; avs_read = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] data);
    @(negedge clk);
    avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = a; avs_writedata = data;
    @(negedge clk);
    avs_chipselect = 1'b0; avs_write = 1'b0;
  endtask

  task automatic wait_at(input int per, input int p);
    int unsigned budget = 0;
    while (!(per_idx == per && gen_pos == p)) begin
      @(posedge clk);
      budget++;
      if (budget > 5000) begin
        wt_req++;
        return;
      end
    end
  endtask

  task automatic set_pwm(input int h, input int l);
    @(posedge clk);
    hi_len = h; lo_len = l;
  endtask

  initial begin
    int base, cur, a, h, l;
    logic [31:0] wd;

    // Reset state
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    rd(2'd0, FULL, 32'd0);
    rd(2'd1, FULL, 32'd0);
    rd(2'd2, FULL, 32'd0);
    rd(2'd3, FULL, 32'd1);

    // 30/70: first publish after the second rise
    @(posedge clk);
    hi_len = 30; lo_len = 70; mode = 0; restart_req++;
    wait_at(1, 50);
    rd(2'd2, 32'h1, 32'h1);
    rd(2'd0, FULL, 32'd30);
    rd(2'd1, FULL, 32'd100);
    rd(2'd2, 32'hD, 32'h0);
    set_pwm(99, 1);
    wait_at(2, 50);
    rd(2'd0, FULL, 32'd30);
    rd(2'd1, FULL, 32'd100);
    wait_at(3, 50);
    rd(2'd0, FULL, 32'd99);
    rd(2'd1, FULL, 32'd100);
    set_pwm(1, 99);
    wait_at(4, 50);
    rd(2'd0, FULL, 32'd99);
    rd(2'd1, FULL, 32'd100);
    wait_at(5, 50);
    rd(2'd0, FULL, 32'd1);
    rd(2'd1, FULL, 32'd100);
    set_pwm(30, 70);

    // Two unread publishes -> overrun, then clear
    wait_at(7, 50);
    rd(2'd2, 32'hD, 32'h9);
    wr(2'd3, 32'h3);
    rd(2'd2, 32'hD, 32'h1);
    rd(2'd3, FULL, 32'd1);
    rd(2'd0, FULL, 32'd30);

    // Input stuck high -> stall
    wait_at(8, 10);
    mode = 1;
    repeat (1100) @(posedge clk);
    rd(2'd2, FULL, 32'h7);
    rd(2'd0, FULL, 32'd0);
    rd(2'd1, FULL, 32'd0);
    @(posedge clk);
    mode = 2;
    repeat (20) @(posedge clk);
    hi_len = 40; lo_len = 60; mode = 0; restart_req++;
    repeat (2) @(posedge clk);
    base = per_idx;
    wait_at(base + 1, 50);
    rd(2'd0, FULL, 32'd40);
    rd(2'd1, FULL, 32'd100);
    rd(2'd2, 32'h4, 32'h4);
    wr(2'd3, 32'h3);
    rd(2'd2, 32'hC, 32'h0);

    // Disable mid-LOW while the pattern changes
    wait_at(base + 2, 60);
    wr(2'd3, 32'h0);
    set_pwm(25, 75);
    repeat (500) @(posedge clk);
    rd(2'd0, FULL, 32'd40);
    rd(2'd1, FULL, 32'd100);
    rd(2'd2, 32'h1, 32'h0);
    rd(2'd3, FULL, 32'd0);
    wait_at(per_idx + 1, 50);
    wr(2'd3, 32'h1);
    @(posedge clk);
    cur = per_idx;
    wait_at(cur + 1, 50);
    rd(2'd0, FULL, 32'd40);
    rd(2'd2, 32'h1, 32'h0);
    wait_at(cur + 2, 50);
    rd(2'd0, FULL, 32'd25);
    rd(2'd1, FULL, 32'd100);

    // Asynchronous reset mid-HIGH
    wait_at(per_idx + 1, 10);
    #2 reset_n = 1'b0;
    #1 rst_snap = avs_readdata;
    rst_req++;
    repeat (40) @(negedge clk);
    reset_n = 1'b1;
    rd(2'd0, FULL, 32'd0);
    rd(2'd1, FULL, 32'd0);
    rd(2'd2, 32'hD, 32'h0);
    rd(2'd3, FULL, 32'd1);
    @(posedge clk);
    cur = per_idx;
    wait_at(cur + 1, 50);
    rd(2'd0, FULL, 32'd0);
    rd(2'd2, 32'h1, 32'h0);
    wait_at(cur + 2, 50);
    rd(2'd0, FULL, 32'd25);
    rd(2'd1, FULL, 32'd100);

    // Randomised traffic against the model
    for (int i = 0; i < 300; i++) begin
      if (i % 25 == 0) begin
        h = $urandom_range(1, 60);
        l = $urandom_range(1, 60);
        set_pwm(h, l);
      end
      repeat ($urandom_range(0, 25)) @(posedge clk);
      a = $urandom_range(0, 3);
      if ($urandom_range(0, 4) != 0) begin
        rd(a[1:0], 32'd0, 32'd0);
      end else begin
        wd = $urandom;
        if (a == 3) wd[0] = ($urandom_range(0, 3) != 0);
        wr(a[1:0], wd);
      end
    end
    wr(2'd3, 32'h1);
    rd(2'd3, FULL, 32'd1);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
